// File: rtl/save_flush_requester.sv
// rtl/save_flush_requester.sv - APF dataslot-write requester that asks the host to persist cart save RAM
// Waits for save-RAM writes to go quiet, then runs the target dataslot-write handshake with retries.
module save_flush_requester #(
   parameter logic [15:0] SLOT_ID         = 16'd1,
   parameter logic [31:0] BRIDGE_BASE     = 32'h2000_0000,
   parameter logic [31:0] QUIET_CYCLES    = 32'd74_250_000,
   parameter logic [23:0] ACK_TIMEOUT     = 24'd7_425_000,
   parameter logic [23:0] COOLDOWN_CYCLES = 24'd742_500,
   parameter logic [1:0]  RETRY_MAX       = 2'd3
) (
   input  logic        clk_74a,
   input  logic        reset,
   input  logic        enable,
   input  logic        loading_done,
   input  logic        save_wr_toggle,
   input  logic [17:0] save_size_bytes,
   input  logic        rtc_inuse,
   output logic [15:0] target_dataslot_id,
   output logic [31:0] target_dataslot_slotoffset,
   output logic [31:0] target_dataslot_bridgeaddr,
   output logic [31:0] target_dataslot_length,
   output logic        target_dataslot_write,
   input  logic        target_dataslot_ack,
   input  logic        target_dataslot_done,
   input  logic [2:0]  target_dataslot_err,
   output logic        flush_busy,
   output logic        flush_error,
   output logic [7:0]  flush_count
);

   typedef enum logic [2:0] {
      S_IDLE, S_QUIET, S_REQ, S_WAIT_DONE, S_COOLDOWN, S_FAILED
   } state_t;

   localparam logic [31:0] QUIET_LAST = QUIET_CYCLES - 32'd1;
   localparam logic [31:0] ACK_LAST   = {8'd0, ACK_TIMEOUT} - 32'd1;
   localparam logic [31:0] COOL_LAST  = {8'd0, COOLDOWN_CYCLES} - 32'd1;

   state_t      r_state;
   state_t      w_state_next;
   logic        r_ld_s1, r_ld_s2;
   logic        r_tg_s1, r_tg_s2, r_tg_prev;
   logic [31:0] r_cnt;
   logic [31:0] r_length;
   logic [15:0] r_id;
   logic [31:0] r_offset;
   logic [31:0] r_bridgeaddr;
   logic        r_pending;
   logic [1:0]  r_retries;
   logic        r_error;
   logic [7:0]  r_count;

   logic [31:0] w_len;
   logic        w_evt;
   logic        w_busy;
   logic        w_cnt_clr, w_cnt_inc, w_latch, w_pend_clr, w_retry_clr;
   logic        w_success, w_fail, w_can_retry;

   assign w_len       = {14'd0, save_size_bytes} + (rtc_inuse ? 32'd16 : 32'd0);
   // Writes during the host's own restore, or to an empty image, never start a flush.
   assign w_evt       = (r_tg_s2 ^ r_tg_prev) & r_ld_s2 & (w_len != 32'd0);
   assign w_busy      = (r_state == S_REQ) || (r_state == S_WAIT_DONE) || (r_state == S_COOLDOWN);
   assign w_can_retry = (r_retries < RETRY_MAX);

   always_ff @(posedge clk_74a) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_cnt_clr    = 1'b0;
      w_cnt_inc    = 1'b0;
      w_latch      = 1'b0;
      w_pend_clr   = 1'b0;
      w_retry_clr  = 1'b0;
      w_success    = 1'b0;
      w_fail       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_evt) begin
               w_state_next = S_QUIET;
               w_cnt_clr    = 1'b1;
            end
         end
         S_QUIET: begin
            if (w_evt) begin
               w_cnt_clr = 1'b1;
            end else if (r_cnt == QUIET_LAST) begin
               if (enable) begin
                  w_state_next = S_REQ;
                  w_cnt_clr    = 1'b1;
                  w_latch      = 1'b1;
                  w_pend_clr   = 1'b1;
               end
            end else begin
               w_cnt_inc = 1'b1;
            end
         end
         S_REQ: begin
            if (target_dataslot_ack) begin
               if (target_dataslot_done) begin
                  w_success = (target_dataslot_err == 3'd0);
                  w_fail    = (target_dataslot_err != 3'd0);
               end else begin
                  w_state_next = S_WAIT_DONE;
               end
            end else if (r_cnt == ACK_LAST) begin
               w_fail = 1'b1;
            end else begin
               w_cnt_inc = 1'b1;
            end
         end
         S_WAIT_DONE: begin
            if (target_dataslot_done) begin
               w_success = (target_dataslot_err == 3'd0);
               w_fail    = (target_dataslot_err != 3'd0);
            end
         end
         S_COOLDOWN: begin
            if (r_cnt == COOL_LAST) begin
               w_state_next = S_REQ;
               w_cnt_clr    = 1'b1;
            end else begin
               w_cnt_inc = 1'b1;
            end
         end
         S_FAILED: begin
            if (w_evt) begin
               w_state_next = S_QUIET;
               w_cnt_clr    = 1'b1;
               w_retry_clr  = 1'b1;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
      if (w_success) begin
         w_state_next = (r_pending || w_evt) ? S_QUIET : S_IDLE;
         w_cnt_clr    = 1'b1;
      end
      if (w_fail) begin
         w_state_next = w_can_retry ? S_COOLDOWN : S_FAILED;
         w_cnt_clr    = 1'b1;
      end
   end

   always_ff @(posedge clk_74a) begin
      if (reset) begin
         r_ld_s1      <= 1'b0;
         r_ld_s2      <= 1'b0;
         r_tg_s1      <= 1'b0;
         r_tg_s2      <= 1'b0;
         r_tg_prev    <= 1'b0;
         r_cnt        <= 32'd0;
         r_length     <= 32'd0;
         r_id         <= SLOT_ID;
         r_offset     <= 32'd0;
         r_bridgeaddr <= BRIDGE_BASE;
         r_pending    <= 1'b0;
         r_retries    <= 2'd0;
         r_error      <= 1'b0;
         r_count      <= 8'd0;
      end else begin
         r_ld_s1   <= loading_done;
         r_ld_s2   <= r_ld_s1;
         r_tg_s1   <= save_wr_toggle;
         r_tg_s2   <= r_tg_s1;
         r_tg_prev <= r_tg_s2;
         if (w_cnt_clr)      r_cnt <= 32'd0;
         else if (w_cnt_inc) r_cnt <= r_cnt + 32'd1;
         if (w_latch) r_length <= w_len;
         // The pending flag must survive retries so a write seen mid-command is not lost.
         if (w_pend_clr)          r_pending <= 1'b0;
         else if (w_evt && w_busy) r_pending <= 1'b1;
         if (w_success) begin
            r_count   <= r_count + 8'd1;
            r_retries <= 2'd0;
            r_error   <= 1'b0;
         end else if (w_fail) begin
            if (w_can_retry) r_retries <= r_retries + 2'd1;
            else             r_error   <= 1'b1;
         end else if (w_retry_clr) begin
            r_retries <= 2'd0;
         end
      end
   end

   assign target_dataslot_id         = r_id;
   assign target_dataslot_slotoffset = r_offset;
   assign target_dataslot_bridgeaddr = r_bridgeaddr;
   assign target_dataslot_length     = r_length;
   assign target_dataslot_write      = (r_state == S_REQ);
   assign flush_busy                 = w_busy;
   assign flush_error                = r_error;
   assign flush_count                = r_count;

endmodule

// File: tb/tb_save_flush_requester.sv
// tb/tb_save_flush_requester.sv - scoreboard bench for save_flush_requester
// Stimulus pushes expected request cycles/lengths; a negedge monitor pops on each write rise.
module tb_save_flush_requester;

   localparam int Q = 100;
   localparam int T = 20;
   localparam int C = 30;

   logic        clk_74a = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b1;
   logic        loading_done = 1'b0;
   logic        save_wr_toggle = 1'b0;
   logic [17:0] save_size_bytes = 18'd0;
   logic        rtc_inuse = 1'b0;
   logic        ack = 1'b0;
   logic        done = 1'b0;
   logic [2:0]  err = 3'd0;
   logic [15:0] target_dataslot_id;
   logic [31:0] target_dataslot_slotoffset;
   logic [31:0] target_dataslot_bridgeaddr;
   logic [31:0] target_dataslot_length;
   logic        target_dataslot_write;
   logic        flush_busy;
   logic        flush_error;
   logic [7:0]  flush_count;

   always #5 clk_74a = ~clk_74a;

   save_flush_requester #(
      .SLOT_ID(16'd1), .BRIDGE_BASE(32'h2000_0000), .QUIET_CYCLES(32'd100),
      .ACK_TIMEOUT(24'd20), .COOLDOWN_CYCLES(24'd30), .RETRY_MAX(2'd3)
   ) dut (
      .clk_74a(clk_74a), .reset(reset), .enable(enable), .loading_done(loading_done),
      .save_wr_toggle(save_wr_toggle), .save_size_bytes(save_size_bytes), .rtc_inuse(rtc_inuse),
      .target_dataslot_id(target_dataslot_id), .target_dataslot_slotoffset(target_dataslot_slotoffset),
      .target_dataslot_bridgeaddr(target_dataslot_bridgeaddr), .target_dataslot_length(target_dataslot_length),
      .target_dataslot_write(target_dataslot_write), .target_dataslot_ack(ack),
      .target_dataslot_done(done), .target_dataslot_err(err),
      .flush_busy(flush_busy), .flush_error(flush_error), .flush_count(flush_count)
   );

   typedef struct {
      int          t;
      logic [31:0] len;
   } exp_t;

   exp_t exp_q[$];
   exp_t m_e;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   n_req = 0;
   int   exp_req = 0;
   int   exp_count = 0;
   int   model_retries = 0;
   logic wr_prev = 1'b0;

   always @(posedge clk_74a) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   always @(negedge clk_74a) begin
      if (target_dataslot_write && !wr_prev) begin
         n_req++;
         if (exp_q.size() == 0) begin
            check("unexpected_request", 32'd1, 32'd0);
         end else begin
            m_e = exp_q.pop_front();
            check("req_cycle", cyc, m_e.t);
            check("req_length", target_dataslot_length, m_e.len);
            check("req_slot_id", {16'd0, target_dataslot_id}, 32'd1);
            check("req_bridgeaddr", target_dataslot_bridgeaddr, 32'h2000_0000);
            check("req_slotoffset", target_dataslot_slotoffset, 32'd0);
         end
      end
      wr_prev = target_dataslot_write;
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk_74a);
         #1;
      end
   endtask

   task automatic flip(output int t);
      save_wr_toggle = ~save_wr_toggle;
      t = cyc;
   endtask

   function automatic logic [31:0] image_len();
      return 32'(save_size_bytes) + (rtc_inuse ? 32'd16 : 32'd0);
   endfunction

   task automatic expect_req(input int t);
      exp_q.push_back('{t, image_len()});
      exp_req++;
   endtask

   task automatic wait_write(output int r);
      int k = 0;
      while (!target_dataslot_write && k < 400) begin
         step();
         k++;
      end
      check("request_seen", {31'd0, target_dataslot_write}, 32'd1);
      r = cyc;
   endtask

   // Host side: ack after ack_dly cycles; done_dly = 0 means done in the same cycle as ack.
   task automatic serve(input int ack_dly, input int done_dly, input logic [2:0] e, output int dcyc);
      int r;
      wait_write(r);
      step(ack_dly);
      ack = 1'b1;
      dcyc = cyc;
      if (done_dly == 0) begin
         done = 1'b1;
         err  = e;
      end
      step();
      ack = 1'b0;
      done = 1'b0;
      err = 3'd0;
      if (done_dly > 0) begin
         step(done_dly - 1);
         done = 1'b1;
         err  = e;
         dcyc = cyc;
         step();
         done = 1'b0;
         err  = 3'd0;
      end
   endtask

   task automatic check_count(input string name);
      check(name, {24'd0, flush_count}, 32'(exp_count % 256));
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int t, r, d, h, n;
      loading_done = 1'b1;
      step(3);
      check("rst_write", {31'd0, target_dataslot_write}, 32'd0);
      check("rst_busy", {31'd0, flush_busy}, 32'd0);
      check("rst_error", {31'd0, flush_error}, 32'd0);
      check("rst_count", {24'd0, flush_count}, 32'd0);
      check("rst_length", target_dataslot_length, 32'd0);
      check("rst_id", {16'd0, target_dataslot_id}, 32'd1);
      check("rst_offset", target_dataslot_slotoffset, 32'd0);
      check("rst_bridge", target_dataslot_bridgeaddr, 32'h2000_0000);
      reset = 1'b0;
      step(5);

      // single write, 8 KiB + RTC
      save_size_bytes = 18'd8192;
      rtc_inuse = 1'b1;
      flip(t);
      expect_req(t + Q + 3);
      serve(5, 3, 3'd0, d);
      exp_count++;
      step(2);
      check_count("single_count");
      check("single_busy", {31'd0, flush_busy}, 32'd0);
      check("single_write", {31'd0, target_dataslot_write}, 32'd0);

      // writes every 50 cycles keep restarting the quiet period
      for (int i = 0; i < 10; i++) begin
         flip(t);
         if (i < 9) step(50);
      end
      expect_req(t + Q + 3);
      serve(2, 2, 3'd0, d);
      exp_count++;
      step(2);
      check_count("burst_count");

      // enable low: request held back until enable rises
      enable = 1'b0;
      flip(t);
      step(Q + 50);
      check("disabled_write", {31'd0, target_dataslot_write}, 32'd0);
      expect_req(cyc + 1);
      enable = 1'b1;
      serve(1, 1, 3'd0, d);
      exp_count++;
      step(2);
      check_count("enable_count");

      // randomized bursts with random host latencies
      for (int b = 0; b < 6; b++) begin
         save_size_bytes = 18'($urandom_range(1, 131072));
         rtc_inuse = 1'($urandom_range(0, 1));
         n = $urandom_range(1, 5);
         for (int i = 0; i < n; i++) begin
            flip(t);
            if (i < n - 1) step($urandom_range(1, 90));
         end
         expect_req(t + Q + 3);
         serve($urandom_range(0, 6), $urandom_range(0, 6), 3'd0, d);
         exp_count++;
         step(3);
         check_count("random_count");
      end

      // every completion fails: first try plus RETRY_MAX retries
      save_size_bytes = 18'd1000;
      rtc_inuse = 1'b0;
      model_retries = 0;
      flip(t);
      expect_req(t + Q + 3);
      for (int i = 0; i < 4; i++) begin
         serve(1, 2, 3'd3, d);
         if (model_retries < 3) begin
            model_retries++;
            expect_req(d + 1 + C);
         end
      end
      step(C + 40);
      check("retry_error", {31'd0, flush_error}, 32'd1);
      check("retry_busy", {31'd0, flush_busy}, 32'd0);
      check_count("retry_count");

      // write during WAIT_DONE: success, then a fresh quiet period from completion
      flip(t);
      expect_req(t + Q + 3);
      wait_write(r);
      step(2);
      ack = 1'b1;
      step();
      ack = 1'b0;
      step(3);
      flip(t);
      step(10);
      done = 1'b1;
      d = cyc;
      expect_req(d + 1 + Q);
      step();
      done = 1'b0;
      exp_count++;
      check_count("pending_count");
      check("pending_error_cleared", {31'd0, flush_error}, 32'd0);
      serve(2, 2, 3'd0, d);
      exp_count++;
      step(2);
      check_count("pending_count2");

      // no ack: write held ACK_TIMEOUT cycles, retry after cooldown
      flip(t);
      expect_req(t + Q + 3);
      wait_write(r);
      h = 0;
      while (target_dataslot_write && h < 100) begin
         step();
         h++;
      end
      check("ack_timeout_hold", h, T);
      check("ack_timeout_busy", {31'd0, flush_busy}, 32'd1);
      expect_req(r + T + C);
      serve(3, 2, 3'd0, d);
      exp_count++;
      step(2);
      check_count("timeout_count");

      // writes ignored while loading_done is low
      loading_done = 1'b0;
      step(5);
      for (int i = 0; i < 3; i++) begin
         flip(t);
         step(10);
      end
      step(Q + 50);
      loading_done = 1'b1;
      step(Q + 20);
      check("no_req_loading", n_req, exp_req);

      // empty image ignored
      save_size_bytes = 18'd0;
      rtc_inuse = 1'b0;
      for (int i = 0; i < 3; i++) begin
         flip(t);
         step(10);
      end
      step(Q + 50);
      check("no_req_empty", n_req, exp_req);

      // reset while requesting
      save_size_bytes = 18'd4096;
      flip(t);
      if (save_wr_toggle) begin
         step();
         flip(t);
      end
      expect_req(t + Q + 3);
      wait_write(r);
      reset = 1'b1;
      step();
      exp_count = 0;
      check("rreq_write", {31'd0, target_dataslot_write}, 32'd0);
      check("rreq_busy", {31'd0, flush_busy}, 32'd0);
      check("rreq_error", {31'd0, flush_error}, 32'd0);
      check_count("rreq_count");
      check("rreq_length", target_dataslot_length, 32'd0);
      reset = 1'b0;
      step(Q + 50);
      check("rreq_no_request", n_req, exp_req);

      step(10);
      check("queue_empty", exp_q.size(), 32'd0);
      check("request_total", n_req, exp_req);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
